// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the MazeRunner command receiver.
// Holds the RX/TX bit-engine state encodings, the byte-assembler states,
// the positive-acknowledge response code and the default timing constants.
package uart_cmd_pkg;

    // 50 MHz system clock / 19200 baud
    localparam int DEF_BAUD_DIV = 2604;
    // Allowed gap between the high byte and the start of the low byte
    localparam int DEF_BYTE_TO  = 131072;

    // Positive acknowledge sent back to the remote
    localparam logic [7:0] ACK = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Same encoding as rx_state_t; prefixed so both can live in one scope
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        HIGH = 1'b0,
        LOW  = 1'b1
    } asm_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine.
// Synchronises RX, detects the start edge, samples mid-bit and delivers a byte.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   RX        : asynchronous serial input, idle high
//   rx_byte   : last received byte, valid while rx_rdy is high
//   rx_rdy    : one-cycle pulse, byte accepted (stop bit was high)
//   frm_err   : one-cycle pulse, stop bit sampled low, byte dropped
//   rx_busy   : a frame is being received (start edge seen, not yet back to idle)
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       rx_busy
);

    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    rx_state_t   state_r;
    rx_state_t   state_nxt_s;
    logic        sync1_r;
    logic        sync2_r;
    logic        prev_r;
    logic [11:0] baud_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  rx_byte_r;
    logic        rx_rdy_r;
    logic        frm_err_r;
    logic        rx_busy_r;
    logic        fall_s;
    logic        baud_done_s;
    logic        cnt_clr_s;
    logic        shift_en_s;
    logic        rdy_set_s;
    logic        ferr_set_s;

    // Two-flop synchroniser plus a history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= RX;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // A low stop bit leaves the line low, so no new edge can appear until
    // RX has returned high: this is what re-arms the receiver after an error.
    assign fall_s = prev_r & ~sync2_r;

    // Sample point: half a bit into the start bit, full bits afterwards
    always_comb begin
        if (state_r == START) begin
            baud_done_s = (baud_cnt_r == HALF_LAST);
        end else begin
            baud_done_s = (baud_cnt_r == BIT_LAST);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (baud_done_s) begin
                    // Line back high at mid start bit: glitch, not a frame
                    if (sync2_r) state_nxt_s = IDLE;
                    else         state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (baud_done_s && (bit_cnt_r == 4'd7)) state_nxt_s = STOP;
                else                                     state_nxt_s = DATA;
            end
            STOP: begin
                if (baud_done_s) state_nxt_s = IDLE;
                else             state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        cnt_clr_s  = 1'b0;
        shift_en_s = 1'b0;
        rdy_set_s  = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            IDLE:  cnt_clr_s = 1'b1;
            START: cnt_clr_s = baud_done_s;
            DATA: begin
                cnt_clr_s  = baud_done_s;
                shift_en_s = baud_done_s;
            end
            STOP: begin
                cnt_clr_s = baud_done_s;
                if (baud_done_s) begin
                    rdy_set_s  = sync2_r;
                    ferr_set_s = ~sync2_r;
                end else begin
                    rdy_set_s  = 1'b0;
                    ferr_set_s = 1'b0;
                end
            end
            default: cnt_clr_s = 1'b1;
        endcase
    end

    // Baud/bit counters, LSB-first shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r <= 12'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            rx_byte_r  <= 8'h00;
            rx_rdy_r   <= 1'b0;
            frm_err_r  <= 1'b0;
            rx_busy_r  <= 1'b0;
        end else begin
            if (cnt_clr_s) baud_cnt_r <= 12'd0;
            else           baud_cnt_r <= baud_cnt_r + 12'd1;

            if (state_r != DATA) bit_cnt_r <= 4'd0;
            else if (shift_en_s) bit_cnt_r <= bit_cnt_r + 4'd1;
            else                 bit_cnt_r <= bit_cnt_r;

            if (shift_en_s) shift_r <= {sync2_r, shift_r[7:1]};
            else            shift_r <= shift_r;

            if (rdy_set_s) rx_byte_r <= shift_r;
            else           rx_byte_r <= rx_byte_r;

            rx_rdy_r  <= rdy_set_s;
            frm_err_r <= ferr_set_s;
            rx_busy_r <= (state_nxt_s != IDLE);
        end
    end

    assign rx_byte = rx_byte_r;
    assign rx_rdy  = rx_rdy_r;
    assign frm_err = frm_err_r;
    assign rx_busy = rx_busy_r;

endmodule

// File: rtl/uart_cmd_rcv.sv
// MazeRunner end of the bluetooth command link.
// Receives two UART bytes (high then low) into a 16-bit command with a
// cmd_rdy handshake, and serialises an 8-bit response back on TX.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   RX / TX      : serial in / out, both idle high, 8N1
//   cmd          : assembled {high, low} command
//   cmd_rdy      : command valid, held until clr_cmd_rdy
//   clr_cmd_rdy  : consumer acknowledge pulse
//   cmd_ovr      : pulse, a new command replaced an unconsumed one
//   frm_err      : pulse, received stop bit was low
//   send_resp    : pulse, start sending resp (ignored while tx_busy)
//   resp         : response byte
//   tx_busy      : response frame in progress
//   resp_sent    : last response fully sent
module uart_cmd_rcv
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV,
    parameter int BYTE_TO  = DEF_BYTE_TO
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_ovr,
    output logic        frm_err,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [17:0] TOUT_LAST = 18'(BYTE_TO - 1);

    logic [7:0]  rx_byte_s;
    logic        rx_rdy_s;
    logic        frm_err_s;
    logic        rx_busy_s;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .rx_byte (rx_byte_s),
        .rx_rdy  (rx_rdy_s),
        .frm_err (frm_err_s),
        .rx_busy (rx_busy_s)
    );

    assign frm_err = frm_err_s;

    // ------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------
    asm_state_t  asm_r;
    asm_state_t  asm_nxt_s;
    logic [7:0]  cmd_hi_r;
    logic [17:0] tout_cnt_r;
    logic [15:0] cmd_r;
    logic        cmd_rdy_r;
    logic        cmd_ovr_r;
    logic        hi_load_s;
    logic        load_s;
    logic        tout_s;
    logic        hi_drop_s;

    // Assembler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_r <= HIGH;
        end else begin
            asm_r <= asm_nxt_s;
        end
    end

    // Assembler next-state logic
    always_comb begin
        asm_nxt_s = asm_r;
        case (asm_r)
            HIGH: begin
                if (rx_rdy_s) asm_nxt_s = LOW;
                else          asm_nxt_s = HIGH;
            end
            LOW: begin
                if (rx_rdy_s || frm_err_s || tout_s) asm_nxt_s = HIGH;
                else                                 asm_nxt_s = LOW;
            end
            default: asm_nxt_s = HIGH;
        endcase
    end

    // Assembler output decode; the timeout only runs while no frame is arriving
    always_comb begin
        hi_load_s = 1'b0;
        load_s    = 1'b0;
        tout_s    = 1'b0;
        hi_drop_s = 1'b0;
        case (asm_r)
            HIGH: hi_load_s = rx_rdy_s;
            LOW: begin
                load_s    = rx_rdy_s;
                tout_s    = ~rx_busy_s & (tout_cnt_r == TOUT_LAST);
                hi_drop_s = ~rx_rdy_s & (frm_err_s | tout_s);
            end
            default: hi_load_s = 1'b0;
        endcase
    end

    // Assembler datapath: high-byte holding, timeout counter, command handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_hi_r   <= 8'h00;
            tout_cnt_r <= 18'd0;
            cmd_r      <= 16'h0000;
            cmd_rdy_r  <= 1'b0;
            cmd_ovr_r  <= 1'b0;
        end else begin
            if (hi_load_s)      cmd_hi_r <= rx_byte_s;
            else if (hi_drop_s) cmd_hi_r <= 8'h00;
            else                cmd_hi_r <= cmd_hi_r;

            // Held (not cleared) while a frame is in flight
            if (asm_r != LOW)    tout_cnt_r <= 18'd0;
            else if (!rx_busy_s) tout_cnt_r <= tout_cnt_r + 18'd1;
            else                 tout_cnt_r <= tout_cnt_r;

            if (load_s) cmd_r <= {cmd_hi_r, rx_byte_s};
            else        cmd_r <= cmd_r;

            // A completing command wins over a same-cycle acknowledge
            if (load_s)           cmd_rdy_r <= 1'b1;
            else if (clr_cmd_rdy) cmd_rdy_r <= 1'b0;
            else                  cmd_rdy_r <= cmd_rdy_r;

            cmd_ovr_r <= load_s & cmd_rdy_r & ~clr_cmd_rdy;
        end
    end

    assign cmd     = cmd_r;
    assign cmd_rdy = cmd_rdy_r;
    assign cmd_ovr = cmd_ovr_r;

    // ------------------------------------------------------------------
    // Response transmitter
    // ------------------------------------------------------------------
    tx_state_t   tx_st_r;
    tx_state_t   tx_st_nxt_s;
    logic [11:0] tx_baud_r;
    logic [3:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_r;
    logic        tx_busy_r;
    logic        resp_sent_r;
    logic        tx_done_s;
    logic        tx_load_s;
    logic        tx_shift_s;
    logic        tx_fin_s;
    logic        tx_nxt_s;

    assign tx_done_s = (tx_baud_r == BIT_LAST);

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_r <= TX_IDLE;
        end else begin
            tx_st_r <= tx_st_nxt_s;
        end
    end

    // TX next-state logic
    always_comb begin
        tx_st_nxt_s = tx_st_r;
        case (tx_st_r)
            TX_IDLE: begin
                if (send_resp) tx_st_nxt_s = TX_START;
                else           tx_st_nxt_s = TX_IDLE;
            end
            TX_START: begin
                if (tx_done_s) tx_st_nxt_s = TX_DATA;
                else           tx_st_nxt_s = TX_START;
            end
            TX_DATA: begin
                if (tx_done_s && (tx_bit_r == 4'd7)) tx_st_nxt_s = TX_STOP;
                else                                  tx_st_nxt_s = TX_DATA;
            end
            TX_STOP: begin
                if (tx_done_s) tx_st_nxt_s = TX_IDLE;
                else           tx_st_nxt_s = TX_STOP;
            end
            default: tx_st_nxt_s = TX_IDLE;
        endcase
    end

    // TX output decode: next line level and datapath strobes
    always_comb begin
        tx_load_s  = 1'b0;
        tx_shift_s = 1'b0;
        tx_fin_s   = 1'b0;
        tx_nxt_s   = tx_r;
        case (tx_st_r)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_load_s = 1'b1;
                    tx_nxt_s  = 1'b0;
                end else begin
                    tx_nxt_s  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_done_s) tx_nxt_s = tx_shift_r[0];
                else           tx_nxt_s = 1'b0;
            end
            TX_DATA: begin
                if (tx_done_s) begin
                    if (tx_bit_r == 4'd7) begin
                        tx_nxt_s = 1'b1;
                    end else begin
                        // Bit 0 of the register is on the line; bit 1 goes next
                        tx_nxt_s   = tx_shift_r[1];
                        tx_shift_s = 1'b1;
                    end
                end else begin
                    tx_nxt_s = tx_r;
                end
            end
            TX_STOP: begin
                tx_nxt_s = 1'b1;
                if (tx_done_s) tx_fin_s = 1'b1;
                else           tx_fin_s = 1'b0;
            end
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // TX datapath and registered line/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_baud_r   <= 12'd0;
            tx_bit_r    <= 4'd0;
            tx_shift_r  <= 8'h00;
            tx_r        <= 1'b1;
            tx_busy_r   <= 1'b0;
            resp_sent_r <= 1'b0;
        end else begin
            if ((tx_st_r == TX_IDLE) || tx_done_s) tx_baud_r <= 12'd0;
            else                                   tx_baud_r <= tx_baud_r + 12'd1;

            if (tx_st_r != TX_DATA) tx_bit_r <= 4'd0;
            else if (tx_done_s)     tx_bit_r <= tx_bit_r + 4'd1;
            else                    tx_bit_r <= tx_bit_r;

            if (tx_load_s)       tx_shift_r <= resp;
            else if (tx_shift_s) tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            else                 tx_shift_r <= tx_shift_r;

            tx_r <= tx_nxt_s;

            if (tx_load_s)     tx_busy_r <= 1'b1;
            else if (tx_fin_s) tx_busy_r <= 1'b0;
            else               tx_busy_r <= tx_busy_r;

            if (tx_load_s)     resp_sent_r <= 1'b0;
            else if (tx_fin_s) resp_sent_r <= 1'b1;
            else               resp_sent_r <= resp_sent_r;
        end
    end

    assign TX        = tx_r;
    assign tx_busy   = tx_busy_r;
    assign resp_sent = resp_sent_r;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Scoreboard bench for uart_cmd_rcv with short baud/timeout settings.
// Stimulus pushes expected commands / response bytes into queues; independent
// monitors pop and compare whenever the DUT presents a command or a TX frame.
`timescale 1ns/1ps
module tb_uart_cmd_rcv;

    localparam int BAUD = 16;
    localparam int TOUT = 400;

    typedef struct packed {
        logic [15:0] cmd;
        logic        ovr;
    } cmd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_ovr;
    logic        frm_err;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tx_busy;
    logic        resp_sent;

    cmd_exp_t    cmd_q[$];
    logic [7:0]  tx_q[$];

    int n_cmp     = 0;
    int n_err     = 0;
    int ferr_seen = 0;
    bit tx_mon_en = 1'b1;

    uart_cmd_rcv #(
        .BAUD_DIV (BAUD),
        .BYTE_TO  (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_ovr     (cmd_ovr),
        .frm_err     (frm_err),
        .send_resp   (send_resp),
        .resp        (resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic exp_cmd(input logic [15:0] c, input logic o);
        cmd_exp_t e;
        e.cmd = c;
        e.ovr = o;
        cmd_q.push_back(e);
    endtask

    // One 8N1 frame, each bit held BAUD clocks. With ack_done set, a one-cycle
    // clr_cmd_rdy is placed on the clock where the command completes
    // (start detect 2 clks + half bit + 9 bits, then +1 rx_rdy, +1 load).
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit ack_done);
        logic [9:0] frame;
        frame = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = frame[i];
            for (int c = 1; c < BAUD; c++) begin
                @(negedge clk);
                if (ack_done && (i == 9)) clr_cmd_rdy = (c == 11) ? 1'b1 : 1'b0;
            end
        end
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic idle_rx(input int n);
        @(negedge clk);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_cmds();
        for (int i = 0; (i < 50) && (cmd_q.size() != 0); i++) @(negedge clk);
        check("cmd_drain", cmd_q.size(), 0);
    endtask

    // Command monitor: a new command is visible as cmd_rdy rising, cmd changing
    // while ready, or an overwrite pulse.
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_cmd = 16'h0000;
    cmd_exp_t    got_e;
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (cmd_rdy && (!prev_rdy || (cmd != prev_cmd) || cmd_ovr)) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cmd_unexpected: got 0x%0h ovr %0b, want none", cmd, cmd_ovr);
                end else begin
                    got_e = cmd_q.pop_front();
                    check("cmd_value", {16'h0000, cmd}, {16'h0000, got_e.cmd});
                    check("cmd_ovr", {31'd0, cmd_ovr}, {31'd0, got_e.ovr});
                end
            end else if (cmd_ovr) begin
                n_cmp++;
                n_err++;
                $display("FAIL cmd_ovr_stray: got 1 with cmd_rdy %0b, want 0", cmd_rdy);
            end
        end
        prev_rdy = cmd_rdy;
        prev_cmd = cmd;
    end

    // Framing-error pulse counter
    always begin
        @(posedge clk);
        #1;
        if (!rst && frm_err) ferr_seen++;
    end

    // TX monitor: on tx_busy rising, every one of the 10*BAUD samples must
    // match the expected frame, then busy drops with resp_sent high.
    logic       tx_prev_busy = 1'b0;
    logic [9:0] tx_frame;
    logic [7:0] tx_exp;
    int         bad_cnt;
    int         busy_low;
    always begin
        @(posedge clk);
        #1;
        if (!rst && tx_mon_en && tx_busy && !tx_prev_busy) begin
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected: got frame start, want none");
            end else begin
                tx_exp   = tx_q.pop_front();
                tx_frame = {1'b1, tx_exp, 1'b0};
                busy_low = 0;
                for (int b = 0; b < 10; b++) begin
                    bad_cnt = 0;
                    for (int s = 0; s < BAUD; s++) begin
                        if ((b != 0) || (s != 0)) begin
                            @(posedge clk);
                            #1;
                        end
                        if (TX !== tx_frame[b]) bad_cnt++;
                        if (tx_busy !== 1'b1) busy_low++;
                    end
                    check($sformatf("tx_bit%0d_bad_samples", b), bad_cnt, 0);
                end
                check("tx_busy_low_in_frame", busy_low, 0);
                @(posedge clk);
                #1;
                check("tx_busy_after_frame", {31'd0, tx_busy}, 32'd0);
                check("resp_sent_after_frame", {31'd0, resp_sent}, 32'd1);
                check("tx_idle_after_frame", {31'd0, TX}, 32'd1);
            end
        end
        tx_prev_busy = tx_busy;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        repeat (5) @(negedge clk);

        // Reset values
        check("rst_TX", {31'd0, TX}, 32'd1);
        check("rst_cmd", {16'h0000, cmd}, 32'h0000_0000);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_cmd_ovr", {31'd0, cmd_ovr}, 32'd0);
        check("rst_frm_err", {31'd0, frm_err}, 32'd0);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
        rst = 1'b0;
        idle_rx(10);

        // Basic command
        exp_cmd(16'h23FF, 1'b0);
        send_byte(8'h23, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        drain_cmds();
        check("ferr_none", ferr_seen, 0);

        // Acknowledge clears next clock, cmd holds
        pulse_clr();
        check("clr_rdy_23FF", {31'd0, cmd_rdy}, 32'd0);
        check("clr_hold_23FF", {16'h0000, cmd}, 32'h0000_23FF);
        exp_cmd(16'h0000, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        drain_cmds();
        pulse_clr();
        check("clr_rdy_0000", {31'd0, cmd_rdy}, 32'd0);
        check("clr_hold_0000", {16'h0000, cmd}, 32'h0000_0000);
        exp_cmd(16'h1234, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        drain_cmds();
        check("rdy_1234", {31'd0, cmd_rdy}, 32'd1);

        // Overwrite without acknowledge, then acknowledge on completion cycle
        pulse_clr();
        exp_cmd(16'hAAAA, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        exp_cmd(16'h5555, 1'b1);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        drain_cmds();
        check("rdy_after_ovr", {31'd0, cmd_rdy}, 32'd1);
        exp_cmd(16'h6699, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        send_byte(8'h99, 1'b1, 1'b1);
        drain_cmds();
        check("rdy_set_wins", {31'd0, cmd_rdy}, 32'd1);

        // Inter-byte timeout discards the stale high byte
        pulse_clr();
        send_byte(8'h23, 1'b1, 1'b0);
        idle_rx(TOUT + 200);
        exp_cmd(16'h4001, 1'b0);
        send_byte(8'h40, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        drain_cmds();

        // Framing error as high byte, then as low byte
        pulse_clr();
        send_byte(8'h23, 1'b0, 1'b0);
        idle_rx(20);
        check("ferr_one", ferr_seen, 1);
        exp_cmd(16'h1122, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        drain_cmds();
        pulse_clr();
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h23, 1'b0, 1'b0);
        idle_rx(20);
        check("ferr_two", ferr_seen, 2);
        exp_cmd(16'h3344, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        drain_cmds();

        // Response frame, with an ignored second request mid-frame
        tx_q.push_back(uart_cmd_pkg::ACK);
        @(negedge clk);
        resp      = uart_cmd_pkg::ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (50) @(negedge clk);
        resp      = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int i = 0; (i < 300) && tx_busy; i++) @(negedge clk);
        check("tx_busy_end", {31'd0, tx_busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("tx_q_drain", tx_q.size(), 0);
        check("resp_sent_hold", {31'd0, resp_sent}, 32'd1);

        // Reset in the middle of a frame
        tx_mon_en = 1'b0;
        @(negedge clk);
        resp      = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx2_busy", {31'd0, tx_busy}, 32'd1);
        check("tx2_resp_sent_clr", {31'd0, resp_sent}, 32'd0);
        check("tx2_start_bit", {31'd0, TX}, 32'd0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_TX", {31'd0, TX}, 32'd1);
        check("mid_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("mid_rst_cmd", {16'h0000, cmd}, 32'h0000_0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("cmd_q_final", cmd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rcv.md
Name: uart_cmd_rcv

Overview:
- MazeRunner-side end of the bluetooth command link. It is the counterpart of the remote-comm transmitter.
- Receives 8N1 UART bytes on RX and assembles high byte then low byte into a 16-bit command, presented with a cmd_rdy handshake.
- Serializes an 8-bit response (normally 0xA5 positive ack) back on TX.
- Sits between the RX/TX pins and the command-processing FSM.

Parameters:
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud).
- BYTE_TO, 131072: clocks allowed between end of high byte and start of low byte before resynchronising.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- RX  in  1  serial input from remote (asynchronous, idle high)
- TX  out  1  serial output to remote (idle high)
- cmd  out  16  assembled command {high byte, low byte}
- cmd_rdy  out  1  command valid; held until cleared
- clr_cmd_rdy  in  1  consumer acknowledge, single-cycle pulse
- cmd_ovr  out  1  one-cycle pulse: new command overwrote an unconsumed one
- frm_err  out  1  one-cycle pulse: stop bit sampled low
- send_resp  in  1  start transmission of resp, single-cycle pulse
- resp  in  8  response byte to transmit
- tx_busy  out  1  transmission in progress
- resp_sent  out  1  level: last response fully sent

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, cmd_ovr=0, frm_err=0, tx_busy=0, resp_sent=0. Reset aborts any RX or TX frame mid-operation and clears the byte assembler to HIGH.
- RX synchronisation: RX passes through a 2-flop synchronizer, initialised to 1 on reset. Start is detected on a synchronized 1->0 transition while the receiver is IDLE.
- RX sampling:
  - First sample at BAUD_DIV/2 after start detection, then every BAUD_DIV clocks.
  - If the start sample reads 1, it is a false start: return to IDLE.
  - 8 data bits are taken LSB first, then the stop bit.
  - Stop = 1: byte valid, rx_rdy pulses one cycle at the stop sample.
  - Stop = 0: byte discarded, frm_err pulses, receiver waits for RX=1 before re-arming.
- Assembler FSM, states HIGH and LOW:
  - HIGH: a valid byte goes into the cmd_hi register, then go to LOW and start the timeout counter.
  - LOW: a valid byte sets cmd={cmd_hi, byte} and cmd_rdy=1 on the cycle after rx_rdy, then go to HIGH.
  - LOW: counter reaching BYTE_TO before a start bit is detected discards cmd_hi and returns to HIGH. The counter freezes once a start bit is detected.
  - A framing error in LOW also returns to HIGH.
- cmd is stable while cmd_rdy=1, unless it is overwritten.
- clr_cmd_rdy clears cmd_rdy on the next edge.
- Completion while cmd_rdy=1: cmd is overwritten, cmd_rdy stays 1, cmd_ovr pulses.
- Simultaneous clr_cmd_rdy and completion: set wins, so cmd_rdy=1 with the new cmd. No cmd_ovr in this case.
- TX FSM, states IDLE, START, DATA, STOP:
  - send_resp in IDLE latches resp, clears resp_sent, sets tx_busy, and drives TX=0 on the next edge.
  - Each bit is held exactly BAUD_DIV clocks; data goes out LSB first; stop bit =1.
  - At the end of the stop bit: tx_busy=0, resp_sent=1, TX=1.
  - Total frame = 10*BAUD_DIV clocks.
  - send_resp while tx_busy=1 is ignored; resp is not re-latched.
- RX and TX are fully independent (full duplex).
- Counters: baud counters are 12 bits (must hold BAUD_DIV); timeout counter is 18 bits; bit counters are 4 bits.

Decomposition:
- Package uart_cmd_pkg holds:
  - typedef enums rx_state_t {IDLE,START,DATA,STOP}, tx_state_t (same encoding), asm_state_t {HIGH,LOW}
  - localparam ACK = 8'hA5
  - default BAUD_DIV and BYTE_TO
- One sub-module, uart_rx_core: synchronizer, bit sampling, rx_byte/rx_rdy/frm_err. The assembler and the TX remain in the top module.
- Bench uses BAUD_DIV=16 and BYTE_TO=400 for short sims.

Test Plan:
- Reset then send bytes 0x23, 0xFF -> cmd=16'h23FF, cmd_rdy rises 1 clk after the second stop sample; no cmd_ovr/frm_err.
- Command 0x0000 then clr_cmd_rdy pulse -> cmd_rdy=0 next clk; cmd holds 0x0000; send 0x12,0x34 -> cmd=16'h1234, cmd_rdy=1.
- Two commands 0xAAAA then 0x5555 without clr -> cmd=16'h5555, cmd_rdy=1, cmd_ovr one pulse; repeat with clr on the completion cycle -> cmd_rdy=1, no cmd_ovr.
- Send 0x23, idle >BYTE_TO clocks, send 0x40, 0x01 -> cmd=16'h4001; the stale 0x23 is not used.
- Byte 0x23 with stop bit forced 0, then 0x11,0x22 -> frm_err pulse, cmd=16'h1122.
- send_resp with resp=0xA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clks.
  - tx_busy stays high for 10*BAUD_DIV clocks, then resp_sent=1.
  - A second send_resp mid-frame is ignored.
  - rst mid-frame -> TX=1, tx_busy=0 next clk.
